spi_controller: RTL and testbench
=================================

Name: spi_controller

Overview:
- SPI mode-0 write-only controller that serialises one 16-bit command frame per host request onto nCS/SCLK/COPI.
- Sits on the host/test side of the configuration SPI link and drives the peripheral that owns the output-enable, PWM-enable and PWM-duty registers.
- Frame format, MSB first: bit15 = write flag, bits14:8 = address, bits7:0 = data.
- Timing is chosen so the peripheral's 2-FF synchronised edge detection always sees every edge.

Parameters:
- CLK_DIV, 4, clk cycles per SCLK half-period; elaboration error if < 3.
- CS_GAP, 4, clk cycles nCS is held high after a frame before the next can start; elaboration error if < 3.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  host request valid
- req_ready  output  1  controller can accept a request (IDLE only)
- req_write  input  1  value placed in frame bit15; 1 = write
- req_addr  input  7  frame bits14:8
- req_data  input  8  frame bits7:0
- busy  output  1  high from accept until done
- done  output  1  one-cycle pulse when the frame and its CS gap are complete
- nCS  output  1  active-low chip select
- SCLK  output  1  serial clock, idle low
- COPI  output  1  serial data, MSB first

Behaviour:
- Clock and reset:
  - One clock, clk. Reset rst_n is asynchronous, active-low.
  - All outputs are registered.
- Reset values: nCS=1, SCLK=0, COPI=0, busy=0, done=0, req_ready=1; state IDLE; shift register, bit counter and phase counter all 0.
- Accept: on a clk edge with req_valid && req_ready, latch {req_write, req_addr, req_data} into a 16-bit shift register. Later changes on req_* are ignored until the next accept.
- FSM states: IDLE, LOW, HIGH, HOLD, GAP.
  - IDLE: req_ready=1, nCS=1, SCLK=0.
    - On accept -> LOW. On the next cycle nCS=0, COPI=bit15, busy=1, req_ready=0.
  - LOW: SCLK=0 for CLK_DIV cycles, COPI stable, then -> HIGH.
  - HIGH: SCLK=1 for CLK_DIV cycles.
    - At exit with bits sent < 16: shift left, drive the next bit on COPI coincident with SCLK falling, -> LOW.
    - After the 16th HIGH: -> HOLD.
  - HOLD: SCLK=0, nCS=0 for CLK_DIV cycles (nCS hold after the last edge), then -> GAP.
  - GAP: nCS=1, COPI=0 for CS_GAP cycles.
    - On the last GAP cycle: done=1 for that cycle, busy falls and req_ready rises on the following cycle, -> IDLE.
- Timing:
  - nCS low for exactly 33*CLK_DIV clk cycles.
  - Exactly 16 SCLK rising edges per frame. COPI never changes while SCLK=1.
  - Accept-to-done latency is 1 + 33*CLK_DIV + CS_GAP cycles; with defaults, 137.
- Back-to-back: req_valid held high is accepted on the first IDLE cycle after done, so nCS is high for at least CS_GAP+1 cycles between frames.
- Counters:
  - Phase counter is $clog2(max(CLK_DIV, CS_GAP)+1) bits and counts down to 0.
  - Bit counter is 5 bits, 0..16, with no wrap.
- req_valid while busy: ignored and not queued. The host must hold it until req_ready.
- Reset mid-frame: immediate return to reset values (nCS=1 asynchronously). The peripheral sees fewer than 16 edges and discards the frame; no done pulse is produced.
- req_write=0: the frame is still shifted out in full. The peripheral ignores it; done still pulses.

Decomposition:
- Shared package spi_pkg:
  - FRAME_W=16.
  - ADDR_W=7.
  - Address constants ADDR_EN_OUT_7_0=1, ADDR_EN_OUT_15_8=2, ADDR_EN_PWM_7_0=3, ADDR_EN_PWM_15_8=4, ADDR_PWM_DUTY=5.
  - FSM state enum.
- Used by this block, the peripheral and the benches.
- One natural sub-module: spi_phase_timer, a loadable down-counter with a zero flag, used for the LOW/HIGH/HOLD/GAP durations.

Test Plan:
- Reset, then accept {1, 7'd1, 8'hA5}: nCS low for 132 cycles, 16 SCLK rises, COPI sampled at rises = 16'h81A5, done at cycle 137.
- Loopback to the SPI peripheral, writing addr 1..5 with 8'h11, 8'h22, 8'h33, 8'h44, 8'h80: peripheral outputs equal those values after each done.
- req_valid held high for two frames: second nCS fall is at least CS_GAP+1 cycles after the first nCS rise; req_ready=0 throughout each frame; the second request is not lost.
- req_write=0, addr 5, data 8'hFF in loopback: done pulses and pwm_duty_cycle is unchanged.
- rst_n asserted at SCLK rise 8 of a write: nCS=1 immediately, no done, peripheral registers unchanged; a following full frame succeeds.
- CLK_DIV=3, CS_GAP=3 build, loopback write of addr 3 with 8'h5A: en_reg_pwm_7_0=8'h5A, nCS low for 99 cycles.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the configuration SPI link:
// frame layout, register addresses and controller states.
package spi_pkg;

  localparam int FRAME_W = 16;
  localparam int ADDR_W  = 7;

  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_7_0  = 7'd1;
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_15_8 = 7'd2;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_7_0  = 7'd3;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_15_8 = 7'd4;
  localparam logic [ADDR_W-1:0] ADDR_PWM_DUTY    = 7'd5;

  typedef logic [2:0] spi_state_t;

  localparam spi_state_t ST_IDLE = 3'd0;
  localparam spi_state_t ST_LOW  = 3'd1;
  localparam spi_state_t ST_HIGH = 3'd2;
  localparam spi_state_t ST_HOLD = 3'd3;
  localparam spi_state_t ST_GAP  = 3'd4;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } spi_frame_t;

endpackage

// File: rtl/spi_phase_timer.sv
// Loadable down-counter that times each SPI phase;
// stops at zero and flags it.
module spi_phase_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 write-only controller: one 16-bit
// command frame per host request, MSB first.
module spi_controller #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       busy,
  output logic       done,
  output logic       nCS,
  output logic       SCLK,
  output logic       COPI
);
  import spi_pkg::*;

  localparam int PH_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int PW     = $clog2(PH_MAX + 1);
  localparam logic [PW-1:0] DIV_M1 = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] GAP_M1 = PW'(CS_GAP - 1);

  if (CLK_DIV < 3) begin : g_bad_div
    $error("spi_controller: CLK_DIV must be >= 3");
  end
  if (CS_GAP < 3) begin : g_bad_gap
    $error("spi_controller: CS_GAP must be >= 3");
  end

  spi_state_t         state;
  logic [FRAME_W-1:0] sh;
  logic [4:0]         bit_cnt;
  logic [PW-1:0]      ph_cnt;
  logic               ph_zero;
  logic               ld;
  logic [PW-1:0]      ld_val;
  logic               accept;

  assign accept = (state == ST_IDLE) && req_valid;

  // Every timed phase except GAP chains into the next one.
  always_comb begin
    ld     = 1'b0;
    ld_val = DIV_M1;
    unique case (1'b1)
      accept: ld = 1'b1;
      (state == ST_LOW) && ph_zero:  ld = 1'b1;
      (state == ST_HIGH) && ph_zero: ld = 1'b1;
      (state == ST_HOLD) && ph_zero: begin
        ld     = 1'b1;
        ld_val = GAP_M1;
      end
      default: ;
    endcase
  end

  spi_phase_timer #(.W(PW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ld),
    .load_val (ld_val),
    .cnt      (ph_cnt),
    .zero     (ph_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      sh        <= '0;
      bit_cnt   <= '0;
      nCS       <= 1'b1;
      SCLK      <= 1'b0;
      COPI      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      done <= 1'b0;
      unique case (1'b1)
        state == ST_IDLE: begin
          if (req_valid) begin
            sh        <= {req_write, req_addr, req_data};
            bit_cnt   <= '0;
            nCS       <= 1'b0;
            COPI      <= req_write;
            busy      <= 1'b1;
            req_ready <= 1'b0;
            state     <= ST_LOW;
          end
        end
        state == ST_LOW: begin
          COPI <= sh[FRAME_W-1];
          if (ph_zero) begin
            SCLK  <= 1'b1;
            state <= ST_HIGH;
          end
        end
        state == ST_HIGH: begin
          if (ph_zero) begin
            SCLK    <= 1'b0;
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd15) begin
              state <= ST_HOLD;
            end else begin
              sh    <= {sh[FRAME_W-2:0], 1'b0};
              COPI  <= sh[FRAME_W-2];
              state <= ST_LOW;
            end
          end
        end
        state == ST_HOLD: begin
          if (ph_zero) begin
            nCS   <= 1'b1;
            COPI  <= 1'b0;
            state <= ST_GAP;
          end
        end
        state == ST_GAP: begin
          // done lands on the final GAP cycle
          if (ph_cnt == PW'(1)) done <= 1'b1;
          if (ph_zero) begin
            busy      <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: default and CLK_DIV=3/CS_GAP=3
// builds, decoded against a behavioural peripheral model.
module tb_spi_controller;
  import spi_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       valid_a, valid_b;
  logic       req_write;
  logic [6:0] req_addr;
  logic [7:0] req_data;
  logic       sel;

  logic ready_a, busy_a, done_a, ncs_a, sclk_a, copi_a;
  logic ready_b, busy_b, done_b, ncs_b, sclk_b, copi_b;

  spi_controller #(.CLK_DIV(4), .CS_GAP(4)) u_a (
    .clk(clk), .rst_n(rst_n), .req_valid(valid_a), .req_ready(ready_a),
    .req_write(req_write), .req_addr(req_addr), .req_data(req_data),
    .busy(busy_a), .done(done_a), .nCS(ncs_a), .SCLK(sclk_a), .COPI(copi_a)
  );

  spi_controller #(.CLK_DIV(3), .CS_GAP(3)) u_b (
    .clk(clk), .rst_n(rst_n), .req_valid(valid_b), .req_ready(ready_b),
    .req_write(req_write), .req_addr(req_addr), .req_data(req_data),
    .busy(busy_b), .done(done_b), .nCS(ncs_b), .SCLK(sclk_b), .COPI(copi_b)
  );

  wire s_ncs   = sel ? ncs_b   : ncs_a;
  wire s_sclk  = sel ? sclk_b  : sclk_a;
  wire s_copi  = sel ? copi_b  : copi_a;
  wire s_ready = sel ? ready_b : ready_a;
  wire s_busy  = sel ? busy_b  : busy_a;
  wire s_done  = sel ? done_b  : done_a;

  int vecs, errs;
  logic [7:0] exp_regs [8];

  // Peripheral model: a frame counts only with exactly 16 rises
  logic [7:0]  pregs [8] = '{default: 8'h00};
  logic [15:0] frames [$];
  logic [15:0] mon_sh = '0;
  int          mon_n = 0;
  int          rd = 0;

  always @(posedge s_sclk or posedge s_ncs) begin
    if (s_ncs === 1'b1) begin
      if (mon_n == 16) begin
        frames.push_back(mon_sh);
        if (mon_sh[15] && mon_sh[14:8] >= 7'd1 && mon_sh[14:8] <= 7'd5)
          pregs[mon_sh[10:8]] = mon_sh[7:0];
      end
      mon_n  = 0;
      mon_sh = '0;
    end else begin
      mon_sh = {mon_sh[14:0], s_copi};
      mon_n  = mon_n + 1;
    end
  end

  task automatic set_valid(input logic v);
    valid_a = v & ~sel;
    valid_b = v & sel;
  endtask

  task automatic run_frame(input logic w, input logic [6:0] a,
                           input logic [7:0] d, input int abort_rise,
                           output int rises, output int ncs_low,
                           output int lat, output int cviol,
                           output int rviol);
    int cyc;
    int t;
    logic ps, pc;
    rises = 0; ncs_low = 0; lat = 0; cviol = 0; rviol = 0;
    @(negedge clk);
    req_write = w; req_addr = a; req_data = d;
    set_valid(1'b1);
    t = 0;
    while (s_ready !== 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    set_valid(1'b0);
    req_data = ~d;
    req_write = ~w;
    cyc = 2; ps = 1'b0; pc = 1'b0;
    while (cyc < 1000) begin
      if (s_ncs === 1'b0) ncs_low++;
      if (s_ready !== 1'b0 || s_busy !== 1'b1) rviol++;
      if (s_sclk && ps && s_copi !== pc) cviol++;
      if (s_sclk && !ps) begin
        rises++;
        if (rises == abort_rise) begin
          rst_n = 1'b0;
          break;
        end
      end
      if (s_done === 1'b1) begin
        lat = cyc;
        break;
      end
      ps = s_sclk; pc = s_copi;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_frame(input logic w, input logic [6:0] a,
                             input logic [7:0] d, input int div,
                             input int gap);
    int rises, nl, lat, cv, rv;
    logic [15:0] want;
    want = {w, a, d};
    run_frame(w, a, d, 0, rises, nl, lat, cv, rv);
    vecs += 5;
    if (lat != 1 + 33 * div + gap) begin
      errs++;
      $display("FAIL latency got %0d want %0d", lat, 1 + 33 * div + gap);
    end
    if (rises != 16) begin
      errs++;
      $display("FAIL sclk_rises got %0d want 16", rises);
    end
    if (nl != 33 * div) begin
      errs++;
      $display("FAIL ncs_low got %0d want %0d", nl, 33 * div);
    end
    if (cv != 0) begin
      errs++;
      $display("FAIL copi_change_while_high got %0d want 0", cv);
    end
    if (rv != 0) begin
      errs++;
      $display("FAIL ready_busy_in_frame got %0d bad cycles want 0", rv);
    end
    @(negedge clk);
    vecs += 3;
    if (s_done !== 1'b0) begin
      errs++;
      $display("FAIL done_width got %b want 0", s_done);
    end
    if (s_ready !== 1'b1) begin
      errs++;
      $display("FAIL ready_after got %b want 1", s_ready);
    end
    if (s_busy !== 1'b0) begin
      errs++;
      $display("FAIL busy_after got %b want 0", s_busy);
    end
    if (w && a >= 7'd1 && a <= 7'd5) exp_regs[a[2:0]] = d;
    vecs++;
    if (rd >= frames.size()) begin
      errs++;
      $display("FAIL frame_seen got none want %h", want);
    end else begin
      if (frames[rd] !== want) begin
        errs++;
        $display("FAIL frame_bits got %h want %h", frames[rd], want);
      end
      rd++;
    end
    for (int i = 1; i <= 5; i++) begin
      vecs++;
      if (pregs[i] !== exp_regs[i]) begin
        errs++;
        $display("FAIL reg%0d got %h want %h", i, pregs[i], exp_regs[i]);
      end
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #20;
    vecs += 6;
    if (ncs_a !== 1'b1) begin errs++; $display("FAIL rst_ncs got %b want 1", ncs_a); end
    if (sclk_a !== 1'b0) begin errs++; $display("FAIL rst_sclk got %b want 0", sclk_a); end
    if (copi_a !== 1'b0) begin errs++; $display("FAIL rst_copi got %b want 0", copi_a); end
    if (busy_a !== 1'b0) begin errs++; $display("FAIL rst_busy got %b want 0", busy_a); end
    if (done_a !== 1'b0) begin errs++; $display("FAIL rst_done got %b want 0", done_a); end
    if (ready_a !== 1'b1) begin errs++; $display("FAIL rst_ready got %b want 1", ready_a); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    sel = 1'b0;
    check_frame(1'b1, 7'd1, 8'hA5, 4, 4);
  endtask

  task automatic test_loopback();
    logic [7:0] vals [5];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h80};
    sel = 1'b0;
    for (int i = 0; i < 5; i++)
      check_frame(1'b1, 7'(i + 1), vals[i], 4, 4);
  endtask

  task automatic test_write0();
    sel = 1'b0;
    check_frame(1'b0, ADDR_PWM_DUTY, 8'hFF, 4, 4);
  endtask

  task automatic test_random();
    sel = 1'b0;
    for (int i = 0; i < 8; i++)
      check_frame(1'($urandom_range(0, 1)), 7'($urandom_range(0, 7)),
                  8'($urandom), 4, 4);
  endtask

  task automatic test_back_to_back();
    int cyc, dones, t_rise, t_fall, rv;
    logic pn, pend;
    sel = 1'b0;
    @(negedge clk);
    req_write = 1'b1; req_addr = 7'd4; req_data = 8'h3C;
    valid_a = 1'b1;
    cyc = 0;
    while (ready_a !== 1'b1 && cyc < 500) begin @(negedge clk); cyc++; end
    @(negedge clk);
    req_addr = 7'd5; req_data = 8'hC3;
    dones = 0; t_rise = -1; t_fall = -1; rv = 0;
    pn = 1'b0; pend = 1'b0;
    for (cyc = 0; cyc < 600 && dones < 2; cyc++) begin
      if (pend) begin valid_a = 1'b0; pend = 1'b0; end
      if (ncs_a === 1'b0 && ready_a !== 1'b0) rv++;
      if (ncs_a && !pn && t_rise < 0) t_rise = cyc;
      if (!ncs_a && pn && t_rise >= 0 && t_fall < 0) t_fall = cyc;
      if (done_a === 1'b1) dones++;
      if (dones == 1 && ready_a === 1'b1 && valid_a) pend = 1'b1;
      pn = ncs_a;
      @(negedge clk);
    end
    valid_a = 1'b0;
    vecs += 4;
    if (dones != 2) begin
      errs++;
      $display("FAIL b2b_dones got %0d want 2", dones);
    end
    if (t_fall - t_rise < 5 || t_fall < 0) begin
      errs++;
      $display("FAIL b2b_gap got %0d want >= 5", t_fall - t_rise);
    end
    if (rv != 0) begin
      errs++;
      $display("FAIL b2b_ready got %0d bad cycles want 0", rv);
    end
    exp_regs[4] = 8'h3C;
    exp_regs[5] = 8'hC3;
    if (frames.size() != rd + 2) begin
      errs++;
      $display("FAIL b2b_frames got %0d want %0d", frames.size() - rd, 2);
    end else begin
      vecs += 2;
      if (frames[rd] !== 16'h843C) begin
        errs++;
        $display("FAIL b2b_first got %h want 843c", frames[rd]);
      end
      if (frames[rd + 1] !== 16'h85C3) begin
        errs++;
        $display("FAIL b2b_second got %h want 85c3", frames[rd + 1]);
      end
      rd += 2;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_abort();
    int rises, nl, lat, cv, rv;
    int fsz;
    sel = 1'b0;
    fsz = frames.size();
    run_frame(1'b1, 7'd2, 8'h77, 8, rises, nl, lat, cv, rv);
    #1;
    vecs += 2;
    if (ncs_a !== 1'b1) begin
      errs++;
      $display("FAIL abort_ncs got %b want 1", ncs_a);
    end
    if (busy_a !== 1'b0) begin
      errs++;
      $display("FAIL abort_busy got %b want 0", busy_a);
    end
    repeat (3) begin
      @(negedge clk);
      vecs++;
      if (done_a !== 1'b0) begin
        errs++;
        $display("FAIL abort_done got %b want 0", done_a);
      end
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vecs += 2;
    if (frames.size() != fsz) begin
      errs++;
      $display("FAIL abort_frame got %0d frames want %0d", frames.size(), fsz);
    end
    if (pregs[2] !== exp_regs[2]) begin
      errs++;
      $display("FAIL abort_reg got %h want %h", pregs[2], exp_regs[2]);
    end
    check_frame(1'b1, 7'd2, 8'h77, 4, 4);
  endtask

  task automatic test_div3();
    sel = 1'b1;
    repeat (2) @(negedge clk);
    check_frame(1'b1, ADDR_EN_PWM_7_0, 8'h5A, 3, 3);
    sel = 1'b0;
  endtask

  initial begin
    vecs = 0; errs = 0;
    sel = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
    req_write = 1'b0; req_addr = '0; req_data = '0;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) exp_regs[i] = 8'h00;
    test_reset();
    test_basic();
    test_loopback();
    test_write0();
    test_random();
    test_back_to_back();
    test_abort();
    test_div3();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
